// File: rtl/time_pkg.sv
// Shared types and constants for the front-panel time-set controller.
package time_pkg;

  localparam int unsigned TIME_W     = 6;
  localparam int unsigned HOUR_MAX   = 23;
  localparam int unsigned MINSEC_MAX = 59;

  typedef logic [TIME_W-1:0] time_t;

  // Encoding doubles as the `field` output value
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_SET_SEC  = 2'd3
  } state_e;

  // Wrap limit of the field being edited
  function automatic time_t field_max(state_e st);
    return (st == ST_SET_HOUR) ? time_t'(HOUR_MAX) : time_t'(MINSEC_MAX);
  endfunction

  // Saturate an out-of-range counter value to the field limit
  function automatic time_t clamp(time_t v, time_t mx);
    return (v > mx) ? mx : v;
  endfunction

endpackage

// File: rtl/time_setter_if.sv
// Button / counter bus between the time-set controller and its neighbours.
interface time_setter_if;
  import time_pkg::*;

  logic        btn_mode;
  logic        btn_inc;
  logic        btn_dec;
  time_t       hour_in;
  time_t       min_in;
  time_t       sec_in;
  time_t       data;
  logic        load_hour;
  logic        load_min;
  logic        load_sec;
  logic        freeze;
  logic [1:0]  field;

  // Controller side
  modport master (
    input  btn_mode, btn_inc, btn_dec, hour_in, min_in, sec_in,
    output data, load_hour, load_min, load_sec, freeze, field
  );

  // Panel / counter side
  modport slave (
    output btn_mode, btn_inc, btn_dec, hour_in, min_in, sec_in,
    input  data, load_hour, load_min, load_sec, freeze, field
  );

endinterface

// File: rtl/time_setter_btn_edge.sv
// Registered rising-edge detector for one debounced button.
// Optional auto-repeat when TIME_SETTER_AUTOREPEAT_EN is defined.
module btn_edge #(
  parameter int unsigned REPEAT_DELAY  = 500,
  parameter int unsigned REPEAT_PERIOD = 100
) (
  input  logic clk,
  input  logic clear,
  input  logic btn_i,
`ifdef TIME_SETTER_AUTOREPEAT_EN
  input  logic clr_i,
`endif
  output logic step_c
);

  if (REPEAT_PERIOD == 0 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_cfg
    $error("btn_edge: REPEAT_PERIOD must lie in 1..REPEAT_DELAY");
  end

  logic btn_q;
  logic arm_q;
  logic rise_c;

  // Previous level plus an arm flag so a button held through reset is not an edge
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      btn_q <= 1'b0;
      arm_q <= 1'b0;
    end else begin
      btn_q <= btn_i;
      arm_q <= 1'b1;
    end
  end

  assign rise_c = btn_i & ~btn_q & arm_q;

`ifdef TIME_SETTER_AUTOREPEAT_EN
  localparam int unsigned CNT_W = $clog2(REPEAT_DELAY + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             rep_c;

  // Hold-time counter: fires at REPEAT_DELAY, then reloads to give REPEAT_PERIOD spacing
  always_comb begin
    cnt_d = '0;
    rep_c = 1'b0;
    if (clr_i || !btn_i || !arm_q) begin
      cnt_d = '0;
    end else if (!btn_q) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q == CNT_W'(REPEAT_DELAY)) begin
      rep_c = 1'b1;
      cnt_d = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Repeat counter register
  always_ff @(posedge clk or posedge clear) begin
    if (clear) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign step_c = rise_c | rep_c;
`else
  assign step_c = rise_c;
`endif

endmodule

// File: rtl/time_setter.sv
// Front-panel time-set controller: edits hour/minute/second fields and
// writes them back to the counters with one-cycle load strobes.
// Optional auto-repeat on inc/dec: define TIME_SETTER_AUTOREPEAT_EN.
module time_setter
  import time_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = 500,
  parameter int unsigned REPEAT_PERIOD = 100
) (
  input  logic          clk,
  input  logic          clear,
  time_setter_if.master bus
);

  logic mode_c, inc_c, dec_c;

  // Mode never auto-repeats: its repeat counter is held cleared
  btn_edge #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_mode (
    .clk(clk), .clear(clear), .btn_i(bus.btn_mode),
`ifdef TIME_SETTER_AUTOREPEAT_EN
    .clr_i(1'b1),
`endif
    .step_c(mode_c)
  );

  btn_edge #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_inc (
    .clk(clk), .clear(clear), .btn_i(bus.btn_inc),
`ifdef TIME_SETTER_AUTOREPEAT_EN
    .clr_i(mode_c),
`endif
    .step_c(inc_c)
  );

  btn_edge #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_dec (
    .clk(clk), .clear(clear), .btn_i(bus.btn_dec),
`ifdef TIME_SETTER_AUTOREPEAT_EN
    .clr_i(mode_c),
`endif
    .step_c(dec_c)
  );

  state_e state_q, state_d;
  time_t  data_q, data_d;
  time_t  mx_c;
  logic   load_hour_q, load_hour_d;
  logic   load_min_q,  load_min_d;
  logic   load_sec_q,  load_sec_d;
  logic   freeze_q,    freeze_d;
  logic   seed_q,      seed_d;

  // Next-state, seeding, wrap arithmetic and strobes
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    load_hour_d = 1'b0;
    load_min_d  = 1'b0;
    load_sec_d  = 1'b0;
    seed_d      = 1'b0;
    mx_c        = field_max(state_q);

    if (mode_c) begin
      // Leaving a field: data keeps the written value this cycle, seed follows next cycle
      case (state_q)
        ST_RUN: begin
          state_d = ST_SET_HOUR;
          data_d  = clamp(bus.hour_in, time_t'(HOUR_MAX));
        end
        ST_SET_HOUR: begin
          state_d     = ST_SET_MIN;
          load_hour_d = 1'b1;
          seed_d      = 1'b1;
        end
        ST_SET_MIN: begin
          state_d    = ST_SET_SEC;
          load_min_d = 1'b1;
          seed_d     = 1'b1;
        end
        ST_SET_SEC: begin
          state_d    = ST_RUN;
          load_sec_d = 1'b1;
        end
      endcase
    end else if (seed_q) begin
      data_d = (state_q == ST_SET_MIN) ? clamp(bus.min_in, time_t'(MINSEC_MAX))
                                       : clamp(bus.sec_in, time_t'(MINSEC_MAX));
    end else if (state_q != ST_RUN && (inc_c ^ dec_c)) begin
      if (inc_c) data_d = (data_q == mx_c) ? '0 : data_q + time_t'(1);
      else       data_d = (data_q == '0) ? mx_c : data_q - time_t'(1);
    end

    // Stay frozen through the second-counter write
    freeze_d = (state_d != ST_RUN) | load_sec_d;
  end

  // State and output registers
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q     <= ST_RUN;
      data_q      <= '0;
      load_hour_q <= 1'b0;
      load_min_q  <= 1'b0;
      load_sec_q  <= 1'b0;
      freeze_q    <= 1'b0;
      seed_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      load_hour_q <= load_hour_d;
      load_min_q  <= load_min_d;
      load_sec_q  <= load_sec_d;
      freeze_q    <= freeze_d;
      seed_q      <= seed_d;
    end
  end

  assign bus.data      = data_q;
  assign bus.field     = 2'(state_q);
  assign bus.load_hour = load_hour_q;
  assign bus.load_min  = load_min_q;
  assign bus.load_sec  = load_sec_q;
  assign bus.freeze    = freeze_q;

endmodule

// File: tb/tb_time_setter.sv
// Self-checking bench for time_setter: directed scenarios plus random
// button/counter activity against a cycle-level behavioural model.
module tb_time_setter;

  localparam int DLY = 5;
  localparam int PER = 2;
`ifdef TIME_SETTER_AUTOREPEAT_EN
  localparam int REP_EXP = 4;
`else
  localparam int REP_EXP = 1;
`endif

  logic clk;
  logic clear;
  time_setter_if ts_if();

  time_setter #(.REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)) dut (
    .clk(clk), .clear(clear), .bus(ts_if)
  );

  int checks;
  int failures;

  // Behavioural model state
  int m_field, m_data, m_load, m_seed;
  bit m_freeze, m_armed, pm, pi, pd;
  int h_inc, h_dec;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input int exp);
    checks++;
    if (got !== 32'(exp)) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int maxv(input int f);
    return (f == 1) ? 23 : 59;
  endfunction

  function automatic int clampv(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Step request for one inc/dec button, h = cycles since the press
  function automatic bit btn_step(input bit b, input bit p, input bit armed, inout int h);
`ifdef TIME_SETTER_AUTOREPEAT_EN
    if (!b) begin h = -1000; return 1'b0; end
    if (!armed) begin h = -1; return 1'b0; end
    if (!p) begin h = 0; return 1'b1; end
    h = h + 1;
    return (h >= DLY) && (((h - DLY) % PER) == 0);
`else
    h = 0;
    return b && !p && armed;
`endif
  endfunction

  task automatic model_reset();
    m_field = 0; m_data = 0; m_load = 0; m_seed = 0;
    m_freeze = 0; m_armed = 0; pm = 0; pi = 0; pd = 0;
    h_inc = -1000; h_dec = -1000;
  endtask

  task automatic model_step();
    bit em, si, sd;
    int nl, ns, mx;
    nl = 0; ns = 0;
    em = m_armed && ts_if.btn_mode && !pm;
    si = btn_step(ts_if.btn_inc, pi, m_armed, h_inc);
    sd = btn_step(ts_if.btn_dec, pd, m_armed, h_dec);
    if (em) begin
      if (h_inc >= 0) h_inc = -1;
      if (h_dec >= 0) h_dec = -1;
      if (m_field == 0) begin
        m_field = 1;
        m_data  = clampv(int'(ts_if.hour_in), 23);
      end else begin
        nl = m_field;
        ns = (m_field < 3) ? m_field + 1 : 0;
        m_field = (m_field + 1) % 4;
      end
    end else if (m_seed != 0) begin
      m_data = clampv((m_seed == 2) ? int'(ts_if.min_in) : int'(ts_if.sec_in), 59);
    end else if (m_field != 0 && si != sd) begin
      mx = maxv(m_field);
      m_data = si ? (m_data + 1) % (mx + 1) : (m_data + mx) % (mx + 1);
    end
    m_seed   = ns;
    m_load   = nl;
    m_freeze = (m_field != 0) || (nl == 3);
    pm = ts_if.btn_mode; pi = ts_if.btn_inc; pd = ts_if.btn_dec;
    m_armed = 1;
  endtask

  task automatic compare();
    check_val("data",      ts_if.data,      m_data);
    check_val("field",     ts_if.field,     m_field);
    check_val("freeze",    ts_if.freeze,    int'(m_freeze));
    check_val("load_hour", ts_if.load_hour, int'(m_load == 1));
    check_val("load_min",  ts_if.load_min,  int'(m_load == 2));
    check_val("load_sec",  ts_if.load_sec,  int'(m_load == 3));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic set_btn(input bit m, input bit i, input bit d);
    ts_if.btn_mode = m; ts_if.btn_inc = i; ts_if.btn_dec = d;
  endtask

  task automatic press_mode();
    set_btn(1, 0, 0); tick();
    set_btn(0, 0, 0); tick();
  endtask

  task automatic do_clear();
    #2 clear = 1'b1;
    #1;
    check_val("clr_field",  ts_if.field,  0);
    check_val("clr_data",   ts_if.data,   0);
    check_val("clr_freeze", ts_if.freeze, 0);
    check_val("clr_loads",  {ts_if.load_hour, ts_if.load_min, ts_if.load_sec}, 0);
    @(posedge clk); #1;
    check_val("clr_hold_loads", {ts_if.load_hour, ts_if.load_min, ts_if.load_sec}, 0);
    #3 clear = 1'b0;
    model_reset();
  endtask

  initial begin
    checks = 0; failures = 0;
    model_reset();
    clear = 1'b1;
    set_btn(1, 1, 1);
    ts_if.hour_in = 6'd22; ts_if.min_in = 6'd0; ts_if.sec_in = 6'd10;

    // Reset state with all buttons held, then release reset
    @(posedge clk); #1;
    check_val("rst_data",   ts_if.data,   0);
    check_val("rst_field",  ts_if.field,  0);
    check_val("rst_freeze", ts_if.freeze, 0);
    check_val("rst_loads",  {ts_if.load_hour, ts_if.load_min, ts_if.load_sec}, 0);
    @(posedge clk); #3 clear = 1'b0;
    repeat (3) tick();
    check_val("held_field", ts_if.field, 0);
    check_val("held_loads", {ts_if.load_hour, ts_if.load_min, ts_if.load_sec}, 0);
    set_btn(0, 0, 0); tick();

    // Hour wrap and hour write-back
    set_btn(1, 0, 0); tick();
    check_val("hour_seed", ts_if.data, 22);
    check_val("hour_field", ts_if.field, 1);
    check_val("hour_freeze", ts_if.freeze, 1);
    set_btn(0, 0, 0); tick();
    set_btn(0, 1, 0); tick(); check_val("hour_inc1", ts_if.data, 23);
    set_btn(0, 0, 0); tick();
    set_btn(0, 1, 0); tick(); check_val("hour_wrap", ts_if.data, 0);
    set_btn(0, 0, 0); tick();
    set_btn(1, 0, 0); tick();
    check_val("load_hour_pulse", ts_if.load_hour, 1);
    check_val("load_hour_data", ts_if.data, 0);
    set_btn(0, 0, 0); tick();
    check_val("load_hour_end", ts_if.load_hour, 0);
    check_val("min_seed", ts_if.data, 0);

    // Minute wrap on decrement and write-back
    set_btn(0, 0, 1); tick(); check_val("min_wrap", ts_if.data, 59);
    set_btn(0, 0, 0); tick();
    set_btn(1, 0, 0); tick();
    check_val("load_min_pulse", ts_if.load_min, 1);
    check_val("load_min_data", ts_if.data, 59);
    set_btn(0, 0, 0); tick();
    check_val("sec_seed", ts_if.data, 10);

    // Mode and inc together in SET_SEC
    set_btn(1, 1, 0); tick();
    check_val("load_sec_pulse", ts_if.load_sec, 1);
    check_val("load_sec_data", ts_if.data, 10);
    check_val("sec_exit_field", ts_if.field, 0);
    check_val("sec_exit_freeze", ts_if.freeze, 1);
    set_btn(0, 0, 0); tick();
    check_val("freeze_fall", ts_if.freeze, 0);
    check_val("load_sec_end", ts_if.load_sec, 0);

    // inc and dec together cancel
    ts_if.hour_in = 6'd5;
    press_mode();
    set_btn(0, 1, 1); tick(); check_val("incdec_cancel", ts_if.data, 5);
    set_btn(0, 0, 0); tick();

    // Clear in the middle of a minute edit
    ts_if.min_in = 6'd62;
    press_mode();
    check_val("min_clamp", ts_if.data, 59);
    set_btn(0, 1, 0); tick();
    set_btn(0, 0, 0);
    do_clear();
    repeat (3) tick();

    // Holding inc in SET_SEC from 0
    ts_if.sec_in = 6'd0;
    repeat (3) press_mode();
    check_val("rep_start", ts_if.data, 0);
    set_btn(0, 1, 0);
    repeat (10) tick();
    set_btn(0, 0, 0); tick();
    check_val("rep_result", ts_if.data, REP_EXP);

    // Random activity against the model
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 3) == 0) ts_if.btn_mode = ~ts_if.btn_mode;
      if ($urandom_range(0, 2) == 0) ts_if.btn_inc  = ~ts_if.btn_inc;
      if ($urandom_range(0, 2) == 0) ts_if.btn_dec  = ~ts_if.btn_dec;
      if ($urandom_range(0, 7) == 0) ts_if.hour_in = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) ts_if.min_in  = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) ts_if.sec_in  = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 299) == 0) do_clear();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
